// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: 64-bit PC, req/gnt/rvalid fetch port, valid/ready output.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects instead of masking them.

module Cla64bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] sum,
    output logic        overflow
);
    logic [63:0] g;
    logic [63:0] p;
    logic [64:0] c;
    logic [15:0] gg;
    logic [15:0] gp;

    assign g = a & b;
    assign p = a ^ b;

    // 4-bit lookahead groups; group carries chained between groups
    always_comb begin
        c  = '0;
        gg = '0;
        gp = '0;
        for (int i = 0; i < 16; i++) begin
            gg[i] = g[4*i+3]
                  | (p[4*i+3] & g[4*i+2])
                  | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                  | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
            gp[i] = &p[4*i +: 4];
            for (int j = 0; j < 3; j++) begin
                c[4*i+j+1] = g[4*i+j] | (p[4*i+j] & c[4*i+j]);
            end
            c[4*i+4] = gg[i] | (gp[i] & c[4*i]);
        end
    end

    assign sum      = p ^ c[63:0];
    assign overflow = c[64] ^ c[63];
endmodule

module pc_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        misalign_trap
`endif
);
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        ST_TRAP  = 2'd3
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic        if_valid_q, if_valid_d;
    logic [63:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [63:0] pc_inc;
    logic        pc_inc_ovf_unused;
    logic [63:0] redir_pc;

    Cla64bit u_pc_add (
        .a        (pc_q),
        .b        (64'd4),
        .sum      (pc_inc),
        .overflow (pc_inc_ovf_unused)
    );

`ifdef FETCH_MISALIGN_TRAP_EN
    logic trap_q, trap_d;
    logic redir_bad;

    assign redir_pc      = redirect_pc;
    assign redir_bad     = |redirect_pc[1:0];
    assign misalign_trap = trap_q;
`else
    assign redir_pc = redirect_pc & ~64'h3;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        trap_d     = 1'b0;
`endif
        if (redirect_valid) begin
            pc_d = redir_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redir_bad) begin
                trap_d     = 1'b1;
                drop_d     = 1'b0;
                if_valid_d = 1'b0;
                state_d    = ST_TRAP;
            end else
`endif
            begin
                unique case (state_q)
                    ST_FETCH: begin
                        if (imem_gnt) begin
                            drop_d  = 1'b1;
                            state_d = ST_WAIT;
                        end
                    end
                    // a response in the same cycle is the stale one
                    ST_WAIT: begin
                        drop_d = ~imem_rvalid;
                        if (imem_rvalid) begin
                            state_d = ST_FETCH;
                        end
                    end
                    ST_HOLD: begin
                        if_valid_d = 1'b0;
                        state_d    = ST_FETCH;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    if (imem_gnt) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = ST_FETCH;
                        end else begin
                            if_valid_d = 1'b1;
                            if_pc_d    = pc_q;
                            if_instr_d = imem_rdata;
                            pc_d       = pc_inc;
                            state_d    = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (if_ready) begin
                        if_valid_d = 1'b0;
                        state_d    = ST_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_q     <= trap_d;
`endif
        end
    end

    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, corner sequences,
// and random traffic against a transaction-level PC model.

module tb_pc_fetch_unit;
    localparam logic [63:0] RPC = 64'h1000;
    localparam bit T = 1'b1;
    localparam bit F = 1'b0;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(RPC)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_trap  (misalign_trap)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          redir;
        logic [63:0] rpc;
        bit          gnt;
        bit          rv;
        logic [31:0] rdata;
        bit          rdy;
        bit          e_req;
        logic [63:0] e_addr;
        bit          e_v;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit r, logic [63:0] rp, bit g, bit v,
                                logic [31:0] d, bit y, bit er,
                                logic [63:0] ea, bit ev,
                                logic [63:0] ep, logic [31:0] ei);
        vec_t x;
        x.redir = r; x.rpc = rp; x.gnt = g; x.rv = v; x.rdata = d;
        x.rdy = y; x.e_req = er; x.e_addr = ea; x.e_v = ev;
        x.e_pc = ep; x.e_instr = ei;
        return x;
    endfunction

    function automatic logic [31:0] memfn(logic [63:0] a);
        return a[31:0] ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF ^ a[63:32];
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        if_ready       = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        chk("rst.req", 64'(imem_req), 64'd1);
        chk("rst.addr", imem_addr, RPC);
        chk("rst.valid", 64'(if_valid), 64'd0);
        chk("rst.pc", if_pc, 64'd0);
        chk("rst.instr", 64'(if_instr), 64'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("rst.trap", 64'(misalign_trap), 64'd0);
`endif
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [63:0] exp_pc;
    logic [63:0] pend_addr;
    bit          pending;
    int          accepts;
    bit          r_redir;
    logic [63:0] r_pc;

    initial begin
        // redir rpc gnt rv rdata rdy | req addr valid pc instr
        vt.push_back(mk(F, 0, T, F, 0, F, T, 64'h1000, F, 0, 0));
        vt.push_back(mk(F, 0, F, T, 32'h00A0_0013, F, F, 64'h1000, F, 0, 0));
        vt.push_back(mk(F, 0, F, F, 0, T, F, 64'h1004, T, 64'h1000, 32'h00A0_0013));
        vt.push_back(mk(F, 0, T, F, 0, F, T, 64'h1004, F, 0, 0));
        vt.push_back(mk(F, 0, F, T, 32'h00B0_0093, F, F, 64'h1004, F, 0, 0));
        for (int k = 0; k < 5; k++)
            vt.push_back(mk(F, 0, F, F, 0, F, F, 64'h1008, T, 64'h1004, 32'h00B0_0093));
        vt.push_back(mk(F, 0, F, F, 0, T, F, 64'h1008, T, 64'h1004, 32'h00B0_0093));
        vt.push_back(mk(F, 0, F, F, 0, F, T, 64'h1008, F, 0, 0));
        vt.push_back(mk(F, 0, T, F, 0, F, T, 64'h1008, F, 0, 0));
        vt.push_back(mk(F, 0, F, F, 0, F, F, 64'h1008, F, 0, 0));
        vt.push_back(mk(T, 64'h2000, F, F, 0, F, F, 64'h1008, F, 0, 0));
        vt.push_back(mk(F, 0, F, T, 32'hDEAD_BEEF, F, F, 64'h2000, F, 0, 0));
        vt.push_back(mk(F, 0, T, F, 0, F, T, 64'h2000, F, 0, 0));
        vt.push_back(mk(F, 0, F, T, 32'h0000_2013, F, F, 64'h2000, F, 0, 0));
        vt.push_back(mk(T, 64'h3000, F, F, 0, T, F, 64'h2004, T, 64'h2000, 32'h0000_2013));
        vt.push_back(mk(F, 0, T, F, 0, F, T, 64'h3000, F, 0, 0));
        vt.push_back(mk(F, 0, F, T, 32'h0000_3013, F, F, 64'h3000, F, 0, 0));
        vt.push_back(mk(F, 0, F, F, 0, T, F, 64'h3004, T, 64'h3000, 32'h0000_3013));
        vt.push_back(mk(T, 64'hFFFF_FFFF_FFFF_FFFC, F, F, 0, F, T, 64'h3004, F, 0, 0));
        vt.push_back(mk(F, 0, T, F, 0, F, T, 64'hFFFF_FFFF_FFFF_FFFC, F, 0, 0));
        vt.push_back(mk(F, 0, F, T, 32'h0000_D013, F, F, 64'hFFFF_FFFF_FFFF_FFFC, F, 0, 0));
        vt.push_back(mk(F, 0, F, F, 0, T, F, 64'h0, T, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_D013));
        vt.push_back(mk(T, 64'h5000, T, F, 0, F, T, 64'h0, F, 0, 0));
        vt.push_back(mk(F, 0, F, F, 0, F, F, 64'h5000, F, 0, 0));
        vt.push_back(mk(F, 0, F, T, 32'h0000_00EE, F, F, 64'h5000, F, 0, 0));
        vt.push_back(mk(F, 0, F, T, 32'h0000_0BAD, F, T, 64'h5000, F, 0, 0));
        vt.push_back(mk(F, 0, T, F, 0, F, T, 64'h5000, F, 0, 0));
        vt.push_back(mk(T, 64'h6000, F, T, 32'h0000_E013, F, F, 64'h5000, F, 0, 0));
        vt.push_back(mk(F, 0, T, F, 0, F, T, 64'h6000, F, 0, 0));
        vt.push_back(mk(F, 0, F, T, 32'h0000_6013, F, F, 64'h6000, F, 0, 0));
        vt.push_back(mk(F, 0, F, T, 32'h0000_0BAD, T, F, 64'h6004, T, 64'h6000, 32'h0000_6013));
        vt.push_back(mk(F, 0, F, F, 0, F, T, 64'h6004, F, 0, 0));

        do_reset();

        foreach (vt[i]) begin
            chk($sformatf("vec%0d.req", i), 64'(imem_req), 64'(vt[i].e_req));
            chk($sformatf("vec%0d.addr", i), imem_addr, vt[i].e_addr);
            chk($sformatf("vec%0d.valid", i), 64'(if_valid), 64'(vt[i].e_v));
            if (vt[i].e_v) begin
                chk($sformatf("vec%0d.pc", i), if_pc, vt[i].e_pc);
                chk($sformatf("vec%0d.instr", i), 64'(if_instr), 64'(vt[i].e_instr));
            end
            redirect_valid = vt[i].redir;
            redirect_pc    = vt[i].rpc;
            imem_gnt       = vt[i].gnt;
            imem_rvalid    = vt[i].rv;
            imem_rdata     = vt[i].rdata;
            if_ready       = vt[i].rdy;
            tick();
        end
        idle();

        // reset while waiting on a response, then a late response in FETCH
        imem_gnt = 1'b1;
        tick();
        idle();
        reset = 1'b1;
        tick();
        chk("midrst.addr", imem_addr, RPC);
        chk("midrst.req", 64'(imem_req), 64'd1);
        reset       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0BAD;
        tick();
        idle();
        chk("late.valid", 64'(if_valid), 64'd0);
        chk("late.req", 64'(imem_req), 64'd1);
        chk("late.addr", imem_addr, RPC);

        do_reset();
`ifdef FETCH_MISALIGN_TRAP_EN
        redirect_valid = 1'b1;
        redirect_pc    = 64'h4002;
        tick();
        idle();
        chk("trap.pulse", 64'(misalign_trap), 64'd1);
        chk("trap.req", 64'(imem_req), 64'd0);
        chk("trap.addr", imem_addr, 64'h4002);
        chk("trap.valid", 64'(if_valid), 64'd0);
        tick();
        chk("trap.pulse_end", 64'(misalign_trap), 64'd0);
        imem_gnt = 1'b1;
        tick();
        tick();
        idle();
        chk("trap.stay_req", 64'(imem_req), 64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h4006;
        tick();
        idle();
        chk("trap.repulse", 64'(misalign_trap), 64'd1);
        chk("trap.readdr", imem_addr, 64'h4006);
        tick();
        chk("trap.repulse_end", 64'(misalign_trap), 64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h4000;
        tick();
        idle();
        chk("trap.exit_req", 64'(imem_req), 64'd1);
        chk("trap.exit_addr", imem_addr, 64'h4000);
        chk("trap.exit_pulse", 64'(misalign_trap), 64'd0);
`else
        redirect_valid = 1'b1;
        redirect_pc    = 64'h4002;
        tick();
        idle();
        chk("mask.addr", imem_addr, 64'h4000);
        chk("mask.req", 64'(imem_req), 64'd1);
`endif
        imem_gnt = 1'b1;
        tick();
        idle();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_4013;
        tick();
        idle();
        chk("align.valid", 64'(if_valid), 64'd1);
        chk("align.pc", if_pc, 64'h4000);
        chk("align.instr", 64'(if_instr), 64'h4013);

        // random traffic against a transaction-level model
        do_reset();
        exp_pc  = RPC;
        pending = 1'b0;
        pend_addr = '0;
        accepts = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (imem_req) chk("rnd.addr", imem_addr, exp_pc);
            chk("rnd.overlap", 64'(imem_req & if_valid), 64'd0);
            r_redir = ($urandom_range(15) == 0);
            if ($urandom_range(3) == 0)
                r_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(3)) * 64'd4;
            else
                r_pc = 64'h8000 + 64'($urandom_range(255)) * 64'd4;
            redirect_valid = r_redir;
            redirect_pc    = r_pc;
            imem_gnt       = imem_req & 1'($urandom_range(1));
            if (pending) begin
                imem_rvalid = 1'($urandom_range(1));
                imem_rdata  = memfn(pend_addr);
            end else begin
                imem_rvalid = ($urandom_range(7) == 0);
                imem_rdata  = $urandom;
            end
            if_ready = 1'($urandom_range(1));
            if (if_valid && if_ready && !r_redir) begin
                chk("rnd.pc", if_pc, exp_pc);
                chk("rnd.instr", 64'(if_instr), 64'(memfn(exp_pc)));
                exp_pc = exp_pc + 64'd4;
                accepts++;
            end
            if (r_redir) exp_pc = r_pc;
            if (imem_rvalid && pending) pending = 1'b0;
            if (imem_gnt) begin
                pending   = 1'b1;
                pend_addr = imem_addr;
            end
            tick();
        end
        idle();
        chk("rnd.progress", 64'(accepts > 50), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
